alu_share_arbiter: RTL and testbench

Shares one combinational `ALU` instance (WIDTH-bit, 4-bit opcode) between NUM_REQ independent requesters, such as execute-stage lanes or an address-generation helper in the pipelined CPU. Each requester uses a valid/ready handshake. The arbiter grants one requester per cycle in round-robin order and registers the ALU result into a single-entry output stage. Results return tagged with the requester index and an illegal-opcode flag.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/ALU.sv | 27 ++
 rtl/rr_arb.sv | 43 ++++
 rtl/alu_share_arbiter.sv | 109 ++++++++++
 tb/tb_alu_share_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings and output-stage state type shared by the ALU and its arbiter
package alu_pkg;

  localparam logic [3:0] OP_NOP        = 4'd0;
  localparam logic [3:0] OP_ADD        = 4'd1;
  localparam logic [3:0] OP_SUB        = 4'd2;
  localparam logic [3:0] OP_AND        = 4'd3;
  localparam logic [3:0] OP_OR         = 4'd4;
  localparam logic [3:0] OP_XOR        = 4'd5;
  localparam logic [3:0] OP_LAST_LEGAL = 4'd5;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op > OP_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/ALU.sv
// rtl/ALU.sv - combinational WIDTH-bit ALU; carry/overflow discarded, illegal opcodes yield 0 with err
module ALU
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic [3:0]       opcode_i,
  output logic [WIDTH-1:0] result_o,
  output logic             err_o
);

  always_comb begin
    result_o = '0;
    err_o    = op_is_illegal(opcode_i);
    case (opcode_i)
      OP_ADD:  result_o = op1_i + op2_i;
      OP_SUB:  result_o = op1_i - op2_i;
      OP_AND:  result_o = op1_i & op2_i;
      OP_OR:   result_o = op1_i | op2_i;
      OP_XOR:  result_o = op1_i ^ op2_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - round-robin arbiter; owns the rotating priority pointer
module rr_arb #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] high_mask;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] pick;

  // Requests at or above the pointer win; otherwise wrap to the lowest index.
  always_comb begin
    high_mask = ~((NUM_REQ'(1) << ptr_q) - NUM_REQ'(1));
    masked    = req & high_mask;
    pick      = (masked != '0) ? masked : req;
    grant     = pick & (~pick + NUM_REQ'(1));
    grant_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_id = ID_W'(i);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one ALU among NUM_REQ requesters with a single-entry registered output
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_op1,
  input  logic [NUM_REQ*WIDTH-1:0]   req_op2,
  input  logic [NUM_REQ*4-1:0]       req_opcode,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic [WIDTH-1:0]           resp_result,
  output logic                       resp_err,
  output logic [15:0]                op_count
);

  out_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               can_accept;
  logic               accept;
  logic [WIDTH-1:0]   alu_op1, alu_op2, alu_result;
  logic [3:0]         alu_opcode;
  logic               alu_err;
  logic [ID_W-1:0]    id_q;
  logic [WIDTH-1:0]   result_q;
  logic               err_q;
  logic [15:0]        op_count_q;

  // rst_n gates the handshake so nothing is offered while the block is held in reset.
  assign can_accept = (state_q == ST_EMPTY) || resp_ready;
  assign accept     = rst_n && can_accept && (grant != '0);
  assign req_ready  = grant & {NUM_REQ{rst_n && can_accept}};

  rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .advance  (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_comb begin
    alu_op1    = '0;
    alu_op2    = '0;
    alu_opcode = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        alu_op1    = req_op1[i*WIDTH +: WIDTH];
        alu_op2    = req_op2[i*WIDTH +: WIDTH];
        alu_opcode = req_opcode[i*4 +: 4];
      end
    end
  end

  ALU #(.WIDTH(WIDTH)) u_alu (
    .op1_i    (alu_op1),
    .op2_i    (alu_op2),
    .opcode_i (alu_opcode),
    .result_o (alu_result),
    .err_o    (alu_err)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL: begin
        if (accept)          state_d = ST_FULL;
        else if (resp_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q       <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      op_count_q <= '0;
    end else if (accept) begin
      id_q       <= grant_id;
      result_q   <= alu_result;
      err_q      <= alu_err;
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign resp_valid  = (state_q == ST_FULL);
  assign resp_id     = id_q;
  assign resp_result = result_q;
  assign resp_err    = err_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed and randomized checks of alu_share_arbiter against a behavioural model
module tb_alu_share_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*W-1:0]  req_op1, req_op2;
  logic [N*4-1:0]  req_opcode;
  logic            resp_valid, resp_ready;
  logic [1:0]      resp_id;
  logic [W-1:0]    resp_result;
  logic            resp_err;
  logic [15:0]     op_count;

  logic [2:0]      r3_valid, r3_ready;
  logic [3*W-1:0]  r3_op1, r3_op2;
  logic [11:0]     r3_opcode;
  logic            r3_resp_valid;
  logic [1:0]      r3_resp_id;
  logic [W-1:0]    r3_resp_result;
  logic            r3_resp_err;
  logic [15:0]     r3_op_count;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_opcode(req_opcode),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_err(resp_err), .op_count(op_count)
  );

  alu_share_arbiter #(.WIDTH(W), .NUM_REQ(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(r3_valid), .req_ready(r3_ready),
    .req_op1(r3_op1), .req_op2(r3_op2), .req_opcode(r3_opcode),
    .resp_valid(r3_resp_valid), .resp_ready(1'b1), .resp_id(r3_resp_id),
    .resp_result(r3_resp_result), .resp_err(r3_resp_err), .op_count(r3_op_count)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: pending requester table plus the visible output register.
  bit          v[N];
  logic [31:0] o1[N], o2[N];
  logic [3:0]  oc[N];
  int          mptr;
  bit          mvalid;
  int          mid;
  logic [31:0] mres;
  bit          merr;
  logic [15:0] mcount;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_grant();
    if (mvalid && !resp_ready) return -1;
    for (int k = 0; k < N; k++) begin
      if (v[(mptr + k) % N]) return (mptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mptr = 0; mvalid = 0; mid = 0; mres = '0; merr = 0; mcount = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = v[i];
      req_op1[i*W +: W]    = o1[i];
      req_op2[i*W +: W]    = o2[i];
      req_opcode[i*4 +: 4] = oc[i];
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    v[i] = 1; oc[i] = op; o1[i] = a; o2[i] = b;
  endtask

  // One clock: check combinational ready and registered outputs, then advance the model.
  task automatic step(input bit keep);
    int g;
    logic [N-1:0] exp_rdy;
    drive();
    #1;
    g = exp_grant();
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("resp_valid", 64'(resp_valid), 64'(mvalid));
    chk("resp_id", 64'(resp_id), 64'(mid));
    chk("resp_result", 64'(resp_result), 64'(mres));
    chk("resp_err", 64'(resp_err), 64'(merr));
    chk("op_count", 64'(op_count), 64'(mcount));
    @(posedge clk);
    if (g >= 0) begin
      mvalid = 1;
      mid    = g;
      mres   = ref_result(oc[g], o1[g], o2[g]);
      merr   = (oc[g] > 4'd5);
      mptr   = (g + 1) % N;
      mcount = mcount + 16'd1;
      if (!keep) v[g] = 0;
    end else if (resp_ready) begin
      mvalid = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0;
    resp_ready = 1;
    r3_valid = '0; r3_op1 = '0; r3_op2 = '0; r3_opcode = '0;
    for (int i = 0; i < N; i++) set_req(i, 4'd1, 32'(i), 32'd1);
    model_reset();
    drive();
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    chk("rst_resp_result", 64'(resp_result), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    for (int i = 0; i < N; i++) v[i] = 0;
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // Single ADD from requester 2
    set_req(2, 4'd1, 32'd10, 32'd5);
    step(0);
    chk("add_valid", 64'(resp_valid), 64'd1);
    chk("add_id", 64'(resp_id), 64'd2);
    chk("add_result", 64'(resp_result), 64'd15);
    chk("add_err", 64'(resp_err), 64'd0);
    step(0);

    // All four requesters held valid: one grant per cycle in rotation
    for (int i = 0; i < N; i++) set_req(i, 4'd1, 32'(i * 100), 32'd1);
    for (int c = 0; c < 8; c++) step(1);
    chk("rr_op_count", 64'(op_count), 64'd9);
    for (int i = 0; i < N; i++) v[i] = 0;
    step(0);

    // Backpressure with a pending SUB result
    set_req(0, 4'd2, 32'd10, 32'd5);
    step(0);
    resp_ready = 0;
    set_req(1, 4'd5, 32'hA, 32'h5);
    for (int c = 0; c < 3; c++) begin
      step(0);
      chk("bp_hold_result", 64'(resp_result), 64'd5);
      chk("bp_hold_valid", 64'(resp_valid), 64'd1);
    end
    resp_ready = 1;
    step(0);
    chk("bp_next_id", 64'(resp_id), 64'd1);
    chk("bp_next_xor", 64'(resp_result), 64'hF);

    // Illegal, NOP and negative-wrap SUB
    set_req(2, 4'd7, 32'd3, 32'd4);
    step(0);
    chk("illegal_result", 64'(resp_result), 64'd0);
    chk("illegal_err", 64'(resp_err), 64'd1);
    set_req(3, 4'd0, 32'd3, 32'd4);
    step(0);
    chk("nop_result", 64'(resp_result), 64'd0);
    chk("nop_err", 64'(resp_err), 64'd0);
    set_req(0, 4'd2, 32'd5, 32'd10);
    step(0);
    chk("sub_neg", 64'(resp_result), 64'hFFFF_FFFB);

    // Reset while FULL drops the pending result
    resp_ready = 0;
    set_req(2, 4'd1, 32'd1, 32'd1);
    step(0);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_count", 64'(op_count), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    model_reset();
    for (int i = 0; i < N; i++) v[i] = 0;
    @(negedge clk);
    rst_n = 1;
    resp_ready = 1;
    set_req(3, 4'd1, 32'd7, 32'd7);
    set_req(1, 4'd3, 32'hFF, 32'h0F);
    drive();
    #1;
    chk("post_rst_first", 64'(req_ready), 64'b0010);
    step(0);
    chk("post_rst_id", 64'(resp_id), 64'd1);

    // op_count wrap from 0xFFFF
    dut.op_count_q = 16'hFFFF;
    mcount = 16'hFFFF;
    step(0);
    chk("count_wrap", 64'(op_count), 64'd0);
    step(0);

    // NUM_REQ=3: pointer wraps 2 -> 0
    r3_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rr3_grant", 64'(r3_ready), 64'(3'b001 << (c % 3)));
      @(posedge clk);
      @(negedge clk);
    end
    r3_valid = '0;

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5)),
                  $urandom, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20)));
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      step(0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
